// File: rtl/fpmu_pkg.sv
// Shared types and saturating arithmetic helpers for the FPMU MAC sequencer.
// Values are carried in a 64-bit signed container; callers extend per signedness.
package fpmu_pkg;

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, SAT, DONE} state_t;

    localparam int XW = 64;
    typedef logic signed [XW-1:0] xval_t;

    typedef struct packed {
        xval_t val;
        logic  hit;
    } sat_res_t;

    function automatic xval_t lim_hi(input int w, input logic sgn);
        return sgn ? (xval_t'(1) <<< (w - 1)) - xval_t'(1) : (xval_t'(1) <<< w) - xval_t'(1);
    endfunction

    function automatic xval_t lim_lo(input int w, input logic sgn);
        return sgn ? -(xval_t'(1) <<< (w - 1)) : xval_t'(0);
    endfunction

    // Clamp a value into the w-bit range of the chosen signedness.
    function automatic sat_res_t clamp(input xval_t v, input int w, input logic sgn);
        sat_res_t r;
        xval_t    hi;
        xval_t    lo;
        hi = lim_hi(w, sgn);
        lo = lim_lo(w, sgn);
        if (v > hi) begin
            r.val = hi;
            r.hit = 1'b1;
        end else if (v < lo) begin
            r.val = lo;
            r.hit = 1'b1;
        end else begin
            r.val = v;
            r.hit = 1'b0;
        end
        return r;
    endfunction

    // Operands fit in w bits, so the 64-bit sum is exact before clamping.
    function automatic sat_res_t sat_add(input xval_t a, input xval_t b, input int w, input logic sgn);
        return clamp(a + b, w, sgn);
    endfunction

endpackage

// File: rtl/fpmu_mac_seq_fpmu.sv
// Combinational fixed-point multiplier: returns product bits
// [WIDTH+FP_POSITIONS-1:FP_POSITIONS]; higher bits are dropped without a flag.
module fpmu #(
    parameter int SIGN         = 1,
    parameter int WIDTH        = 8,
    parameter int FP_POSITIONS = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_p
);
    localparam int PW = WIDTH + FP_POSITIONS;

    logic [PW-1:0] w_ea;
    logic [PW-1:0] w_eb;
    logic [PW-1:0] w_full;

    // Only the low PW product bits are needed, so a PW x PW multiply suffices.
    generate
        if (SIGN != 0) begin : g_signed
            assign w_ea = PW'($signed(i_a));
            assign w_eb = PW'($signed(i_b));
        end else begin : g_unsigned
            assign w_ea = PW'(i_a);
            assign w_eb = PW'(i_b);
        end
    endgenerate

    assign w_full = w_ea * w_eb;
    assign o_p    = WIDTH'(w_full >> FP_POSITIONS);

endmodule

// File: rtl/fpmu_mac_seq.sv
// Dot-product sequencer: streams operand pairs through one FPMU, accumulates
// with saturation and hands back one clamped result per job.
module fpmu_mac_seq
    import fpmu_pkg::*;
#(
    parameter int SIGN         = 1,
    parameter int WIDTH        = 8,
    parameter int FP_POSITIONS = 4,
    parameter int ACC_WIDTH    = 16,
    parameter int MAX_LEN      = 64,
    localparam int LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_cfg_len,
    output logic             o_busy,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_sat
);
    state_t             r_state;
    state_t             w_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_count;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_prod;
    logic               r_prod_vld;
    logic               r_sat;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_sat;

    logic [WIDTH-1:0]   w_prod;
    logic [LEN_W-1:0]   w_len_clamp;
    logic               w_accept;
    logic               w_last;
    xval_t              w_acc_x;
    xval_t              w_prod_x;
    sat_res_t           w_add;
    sat_res_t           w_clamp;

    fpmu #(
        .SIGN         (SIGN),
        .WIDTH        (WIDTH),
        .FP_POSITIONS (FP_POSITIONS)
    ) u_fpmu (
        .i_a (i_in_a),
        .i_b (i_in_b),
        .o_p (w_prod)
    );

    generate
        if (SIGN != 0) begin : g_ext_s
            assign w_acc_x  = xval_t'($signed(r_acc));
            assign w_prod_x = xval_t'($signed(r_prod));
        end else begin : g_ext_u
            assign w_acc_x  = xval_t'(r_acc);
            assign w_prod_x = xval_t'(r_prod);
        end
    endgenerate

    assign w_add   = sat_add(w_acc_x, w_prod_x, ACC_WIDTH, SIGN != 0);
    assign w_clamp = clamp(w_acc_x, WIDTH, SIGN != 0);

    assign w_len_clamp = (i_cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_cfg_len;
    assign o_in_ready  = (r_state == RUN) && (r_count < r_len);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_last      = w_accept && (r_count == r_len - 1'b1);

    assign o_busy      = (r_state != IDLE);
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_sat   = r_out_sat;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = (w_len_clamp != '0) ? RUN : SAT;
            RUN:     if (w_last) w_next = FLUSH;
            FLUSH:   w_next = SAT;
            SAT:     w_next = DONE;
            DONE:    if (i_out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_prod_vld <= w_accept;
            if (w_accept) begin
                r_prod  <= w_prod;
                r_count <= r_count + 1'b1;
            end
            // Product register drains one cycle behind the accept, through FLUSH.
            if (r_prod_vld) begin
                r_acc <= ACC_WIDTH'(w_add.val);
                if (w_add.hit) r_sat <= 1'b1;
            end
            case (r_state)
                IDLE: if (i_start) begin
                    r_len   <= w_len_clamp;
                    r_count <= '0;
                    r_acc   <= '0;
                    r_sat   <= 1'b0;
                end
                SAT: begin
                    r_out_data  <= WIDTH'(w_clamp.val);
                    r_out_sat   <= r_sat | w_clamp.hit;
                    r_out_valid <= 1'b1;
                end
                DONE: if (i_out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
